// File: rtl/round_sequencer_if.sv
// Handshake bundle between round_sequencer and its button/compare/timer/display neighbours.
// master = sequencer side, slave = environment side.
interface round_sequencer_if;
    logic       btn_p;
    logic       check_valid;
    logic [5:0] check_result;
    logic       timer_finish;
    logic       gen_random;
    logic       timer_set;
    logic       timer_en;
    logic       check_start;
    logic [1:0] led_sel;
    logic [1:0] seg_sel;
    logic [3:0] tries_left;
    logic [7:0] score;

    modport master (
        input  btn_p, check_valid, check_result, timer_finish,
        output gen_random, timer_set, timer_en, check_start,
        output led_sel, seg_sel, tries_left, score
    );

    modport slave (
        output btn_p, check_valid, check_result, timer_finish,
        input  gen_random, timer_set, timer_en, check_start,
        input  led_sel, seg_sel, tries_left, score
    );
endinterface

// File: rtl/round_sequencer.sv
// Guessing-game round FSM: arms a round, launches compares, decides WIN/LOSE, drives display selects.
// Optional saturating win counter enabled by ROUND_SEQUENCER_SCORE_EN.
module round_sequencer #(
    parameter int MAX_TRIES = 8,
    parameter int CHK_WAIT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    round_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_PLAY, S_CHECK, S_WIN, S_LOSE
    } state_t;

    state_t     r_state, w_next;
    logic       r_gen_random, r_timer_set, r_timer_en, r_check_start;
    logic [1:0] r_led_sel, r_seg_sel;
    logic [3:0] r_tries, r_wait;

    logic       w_match, w_timeout, w_launch;
    logic       w_timer_en;
    logic [1:0] w_led_sel, w_seg_sel;
    state_t     w_miss_dest;

    assign w_match     = (bus.check_result == 6'h3F);
    assign w_timeout   = (r_wait == 4'(CHK_WAIT - 1));
    assign w_miss_dest = (r_tries == 4'd0) ? S_LOSE : S_PLAY;
    assign w_launch    = (r_state == S_PLAY) && (w_next == S_CHECK);

    always_comb begin
        w_next     = r_state;
        w_timer_en = 1'b0;
        w_led_sel  = 2'd0;
        w_seg_sel  = 2'd0;
        case (r_state)
            S_IDLE:  if (bus.btn_p) w_next = S_ARM;
            S_ARM:   w_next = S_PLAY;
            S_PLAY: begin
                // timer expiry beats a coincident submit
                if (bus.timer_finish)  w_next = S_LOSE;
                else if (bus.btn_p)    w_next = S_CHECK;
            end
            S_CHECK: begin
                if (bus.check_valid) begin
                    if (w_match)                w_next = S_WIN;
                    else if (bus.timer_finish)  w_next = S_LOSE;
                    else                        w_next = w_miss_dest;
                end else if (bus.timer_finish) begin
                    w_next = S_LOSE;
                end else if (w_timeout) begin
                    w_next = w_miss_dest;
                end
            end
            S_WIN, S_LOSE: if (bus.btn_p) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        // outputs are registered, so decode them from the state being entered
        case (w_next)
            S_PLAY, S_CHECK: begin
                w_timer_en = 1'b1;
                w_led_sel  = 2'd2;
                w_seg_sel  = 2'd1;
            end
            S_WIN: begin
                w_led_sel = 2'd1;
                w_seg_sel = 2'd2;
            end
            S_LOSE: begin
                w_led_sel = 2'd3;
                w_seg_sel = 2'd3;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_gen_random  <= 1'b0;
            r_timer_set   <= 1'b0;
            r_timer_en    <= 1'b0;
            r_check_start <= 1'b0;
            r_led_sel     <= 2'd0;
            r_seg_sel     <= 2'd0;
            r_tries       <= 4'd0;
            r_wait        <= 4'd0;
        end else begin
            r_state       <= w_next;
            r_gen_random  <= (w_next == S_ARM);
            r_timer_set   <= (w_next == S_ARM);
            r_timer_en    <= w_timer_en;
            r_check_start <= w_launch;
            r_led_sel     <= w_led_sel;
            r_seg_sel     <= w_seg_sel;
            if (w_next == S_ARM)
                r_tries <= 4'(MAX_TRIES);
            else if (w_launch)
                r_tries <= r_tries - 4'd1;
            // counts CHECK cycles already spent; zero on the first one
            r_wait <= ((r_state == S_CHECK) && (w_next == S_CHECK)) ? r_wait + 4'd1 : 4'd0;
        end
    end

    assign bus.gen_random  = r_gen_random;
    assign bus.timer_set   = r_timer_set;
    assign bus.timer_en    = r_timer_en;
    assign bus.check_start = r_check_start;
    assign bus.led_sel     = r_led_sel;
    assign bus.seg_sel     = r_seg_sel;
    assign bus.tries_left  = r_tries;

`ifdef ROUND_SEQUENCER_SCORE_EN
    logic [7:0] r_score;

    always_ff @(posedge clk) begin
        if (rst)
            r_score <= 8'h00;
        else if ((w_next == S_WIN) && (r_state != S_WIN) && (r_score != 8'hFF))
            r_score <= r_score + 8'h01;
    end

    assign bus.score = r_score;
`else
    assign bus.score = 8'h00;
`endif
endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter MAX_TRIES, default 8, guesses allowed per round (1..15).
REQ-002 Parameter CHK_WAIT, default 15, cycles allowed for check_valid after check_start (1..15).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_p  input  1  one-cycle start/submit pulse, already edge-captured.
REQ-006 check_valid  input  1  one-cycle pulse; check_result is valid in this cycle.
REQ-007 check_result  input  6  three 2-bit digit scores; 6'h3F means exact match.
REQ-008 timer_finish  input  1  level; countdown has reached zero.
REQ-009 gen_random  output  1  one-cycle pulse requesting a new target.
REQ-010 timer_set  output  1  one-cycle pulse reloading the countdown.
REQ-011 timer_en  output  1  level; countdown runs while high.
REQ-012 check_start  output  1  one-cycle pulse launching a compare.
REQ-013 led_sel  output  2  LED mux select (0 off, 1 flow, 2 result, 3 all-on).
REQ-014 seg_sel  output  2  segment mux select (0 zeros, 1 time, 2 all-8, 3 all-4).
REQ-015 tries_left  output  4  remaining guesses.
REQ-016 score  output  8  rounds won, saturating.

Function
REQ-017 States SHALL be IDLE, ARM, PLAY, CHECK, WIN, LOSE, all outputs registered.
REQ-018 IDLE: led_sel=0, seg_sel=0, timer_en=0; btn_p -> ARM.
REQ-019 ARM (exactly 1 cycle): gen_random=1, timer_set=1, tries_left<=MAX_TRIES; -> PLAY.
REQ-020 PLAY: timer_en=1, led_sel=2, seg_sel=1; btn_p -> CHECK with check_start=1 in the first CHECK cycle and tries_left decremented by 1 on the same edge.
REQ-021 PLAY with timer_finish=1 -> LOSE; if btn_p and timer_finish coincide, timer_finish wins and no check is launched.
REQ-022 CHECK: timer_en=1, btn_p ignored; check_valid with result 6'h3F -> WIN; other result with tries_left=0 -> LOSE; otherwise -> PLAY.
REQ-023 CHECK: timer_finish asserted before check_valid -> LOSE; if both arrive in the same cycle, a 6'h3F result -> WIN, any other -> LOSE.
REQ-024 CHECK: no check_valid within CHK_WAIT cycles after check_start -> treated as a miss (same branch as non-match).
REQ-025 WIN: timer_en=0 (time frozen), led_sel=1, seg_sel=2; score increments once on entry, saturating at 8'hFF.
REQ-026 LOSE: timer_en=0, led_sel=3, seg_sel=3; score unchanged.
REQ-027 WIN/LOSE: btn_p -> IDLE; tries_left holds until the next ARM.
REQ-028 check_valid outside CHECK SHALL be ignored.
REQ-029 gen_random, timer_set and check_start SHALL never be high for more than one consecutive cycle.

Reset
REQ-030 rst SHALL override all inputs in the cycle it is sampled high, from any state including CHECK.
REQ-031 Reset values: state=IDLE, gen_random=0, timer_set=0, timer_en=0, check_start=0, led_sel=0, seg_sel=0, tries_left=0, score=0, wait counter=0.
REQ-032 A compare in flight at reset SHALL be abandoned; its later check_valid is ignored (state is IDLE).

Configuration
REQ-033 Macro ROUND_SEQUENCER_SCORE_EN defined: score counter per REQ-025.
REQ-034 Macro undefined: no score register; score tied to 8'h00; all other behaviour identical.

Verification
REQ-035 Reset, btn_p, 3 non-match results (6'h15), then 6'h3F -> tries_left 8,7,6,5,4; WIN; score=1; led_sel=1, seg_sel=2.
REQ-036 MAX_TRIES=2, two 6'h00 results -> LOSE after the second check_valid; tries_left=0; led_sel=3; score unchanged.
REQ-037 In PLAY, timer_finish and btn_p in the same cycle -> LOSE next cycle, check_start never asserted.
REQ-038 In CHECK, withhold check_valid 15 cycles -> return to PLAY on cycle 16 with tries_left decremented; late check_valid ignored.
REQ-039 rst asserted in CHECK with a 6'h3F check_valid one cycle later -> IDLE, score=0, no WIN.
REQ-040 256 consecutive wins with SCORE_EN defined -> score holds 8'hFF; macro undefined -> score stays 8'h00.
